// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and elaboration helpers for the HI/LO
// multiply/divide unit.
package muldiv_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_DIV   = 4'd1;
   localparam logic [3:0] OP_DIVU  = 4'd2;
   localparam logic [3:0] OP_MFHI  = 4'd3;
   localparam logic [3:0] OP_MFLO  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MUL   = 4'd7;
   localparam logic [3:0] OP_MULT  = 4'd8;
   localparam logic [3:0] OP_MULTU = 4'd9;
   localparam logic [3:0] OP_MADD  = 4'd10;
   localparam logic [3:0] OP_MADDU = 4'd11;
   localparam logic [3:0] OP_MSUB  = 4'd12;
   localparam logic [3:0] OP_MSUBU = 4'd13;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   localparam int MUL_LAT_MIN = 1;

   // A zero-deep multiplier chain would leave nothing between operands and HI/LO.
   function automatic int mul_lat_clamp(input int lat);
      return (lat < MUL_LAT_MIN) ? MUL_LAT_MIN : lat;
   endfunction

   function automatic logic is_mul_class(input logic [3:0] op);
      return (op >= OP_MUL) && (op <= OP_MSUBU);
   endfunction

   function automatic logic is_div_class(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic mul_is_signed(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// done_o pulses one cycle after the last iteration; quotient/remainder then hold.
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   diff_s;

   assign trial_s = {rem_q, quo_q[WIDTH-1]};
   assign diff_s  = trial_s - {1'b0, dvs_q};

   // Next-state: load on start, one restoring step per busy cycle.
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (abort_i) begin
         busy_d = 1'b0;
         cnt_d  = {CW{1'b0}};
      end else if (start_i) begin
         rem_d  = {WIDTH{1'b0}};
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
         cnt_d  = CW'(WIDTH);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (!diff_s[WIDTH]) begin
            rem_d = diff_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = trial_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q  <= {WIDTH{1'b0}};
         quo_q  <= {WIDTH{1'b0}};
         dvs_q  <= {WIDTH{1'b0}};
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign done_o      = done_q;
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_iter.sv
// MIPS HI/LO multiply/divide unit: pipelined multiplier with accumulate,
// iterative divider with sign fix-up, valid/ready request port and flush.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             Clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] rs_in,
   input  logic [WIDTH-1:0] rt_in,
   output logic [WIDTH-1:0] res_out,
   output logic             res_valid,
   output logic             busy,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int LAT = mul_lat_clamp(MUL_LAT);
   localparam int W2  = 2 * WIDTH;
   localparam int LCW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d;
   logic             res_valid_q, res_valid_d;
   logic [3:0]       op_q, op_d;
   logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
   logic [W2-1:0]    pipe_q [LAT];
   logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic             div0_q, div0_d, ovf_q, ovf_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;

   logic             accept_s, mf_fire_s, mul_start_s, div_start_s, div_done_s;
   logic             div_signed_s, a_neg_s, b_neg_s;
   logic [W2-1:0]    a_ext_s, b_ext_s, prod_s, acc_s, mul_final_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s, quo_s, rem_s, quo_fix_s, rem_fix_s;

   assign accept_s    = req_valid && req_ready && !flush;
   assign mf_fire_s   = accept_s && ((req_op == OP_MFHI) || (req_op == OP_MFLO));
   assign mul_start_s = accept_s && is_mul_class(req_op);
   assign div_start_s = accept_s && is_div_class(req_op);

   assign a_ext_s = mul_is_signed(req_op) ? {{WIDTH{rs_in[WIDTH-1]}}, rs_in}
                                          : {{WIDTH{1'b0}}, rs_in};
   assign b_ext_s = mul_is_signed(req_op) ? {{WIDTH{rt_in[WIDTH-1]}}, rt_in}
                                          : {{WIDTH{1'b0}}, rt_in};
   assign prod_s  = a_ext_s * b_ext_s;
   assign acc_s   = {hi_q, lo_q};

   // Accumulate is applied on the last pipeline stage, against the live HI/LO.
   always_comb begin
      mul_final_s = pipe_q[LAT-1];
      case (op_q)
         OP_MADD, OP_MADDU: mul_final_s = acc_s + pipe_q[LAT-1];
         OP_MSUB, OP_MSUBU: mul_final_s = acc_s - pipe_q[LAT-1];
         default:           mul_final_s = pipe_q[LAT-1];
      endcase
   end

   assign div_signed_s = (req_op == OP_DIV);
   assign a_neg_s      = div_signed_s && rs_in[WIDTH-1];
   assign b_neg_s      = div_signed_s && rt_in[WIDTH-1];
   assign a_mag_s      = a_neg_s ? ({WIDTH{1'b0}} - rs_in) : rs_in;
   assign b_mag_s      = b_neg_s ? ({WIDTH{1'b0}} - rt_in) : rt_in;
   assign quo_fix_s    = q_neg_q ? ({WIDTH{1'b0}} - quo_s) : quo_s;
   assign rem_fix_s    = r_neg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;

   muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk_i       (Clk),
      .rst_ni      (resetn),
      .start_i     (div_start_s),
      .abort_i     (flush),
      .dividend_i  (a_mag_s),
      .divisor_i   (b_mag_s),
      .done_o      (div_done_s),
      .quotient_o  (quo_s),
      .remainder_o (rem_s)
   );

   // Control FSM and HI/LO/result next-state; flush discards everything pending.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      res_d       = res_q;
      res_valid_d = 1'b0;
      op_d        = op_q;
      lat_cnt_d   = lat_cnt_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      div0_d      = div0_q;
      ovf_d       = ovf_q;
      dvd_d       = dvd_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  case (req_op)
                     OP_MTHI: hi_d  = rs_in;
                     OP_MTLO: lo_d  = rs_in;
                     OP_MFHI: res_d = hi_q;
                     OP_MFLO: res_d = lo_q;
                     OP_DIV, OP_DIVU: begin
                        state_d = ST_DIV;
                        q_neg_d = a_neg_s ^ b_neg_s;
                        r_neg_d = a_neg_s;
                        div0_d  = (rt_in == {WIDTH{1'b0}});
                        ovf_d   = div_signed_s && (rs_in == MIN_NEG) && (rt_in == {WIDTH{1'b1}});
                        dvd_d   = rs_in;
                     end
                     default: begin
                        if (is_mul_class(req_op)) begin
                           state_d   = ST_MUL;
                           op_d      = req_op;
                           lat_cnt_d = {LCW{1'b0}};
                        end else begin
                           state_d = ST_IDLE;
                        end
                     end
                  endcase
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL: begin
               if (lat_cnt_q == LCW'(LAT - 1)) begin
                  state_d = ST_IDLE;
                  if (op_q == OP_MUL) begin
                     res_d       = mul_final_s[WIDTH-1:0];
                     res_valid_d = 1'b1;
                  end else begin
                     hi_d = mul_final_s[W2-1:WIDTH];
                     lo_d = mul_final_s[WIDTH-1:0];
                  end
               end else begin
                  lat_cnt_d = lat_cnt_q + LCW'(1);
               end
            end
            ST_DIV: begin
               if (div_done_s) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_DIV;
               end
            end
            ST_FIX: begin
               state_d = ST_IDLE;
               if (div0_q) begin
                  lo_d = {WIDTH{1'b1}};
                  hi_d = dvd_q;
               end else if (ovf_q) begin
                  lo_d = MIN_NEG;
                  hi_d = {WIDTH{1'b0}};
               end else begin
                  lo_d = quo_fix_s;
                  hi_d = rem_fix_s;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Architectural and control registers.
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         hi_q        <= {WIDTH{1'b0}};
         lo_q        <= {WIDTH{1'b0}};
         res_q       <= {WIDTH{1'b0}};
         res_valid_q <= 1'b0;
         op_q        <= OP_NOP;
         lat_cnt_q   <= {LCW{1'b0}};
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         dvd_q       <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         op_q        <= op_d;
         lat_cnt_q   <= lat_cnt_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         div0_q      <= div0_d;
         ovf_q       <= ovf_d;
         dvd_q       <= dvd_d;
      end
   end

   // Multiplier retiming chain; stage 0 only loads on an accepted multiply.
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < LAT; i++) pipe_q[i] <= {W2{1'b0}};
      end else begin
         if (mul_start_s) pipe_q[0] <= prod_s;
         for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // An MF read owns the result port in its cycle, even over a coincident MUL pulse.
   assign res_out   = mf_fire_s ? ((req_op == OP_MFHI) ? hi_q : lo_q) : res_q;
   assign res_valid = res_valid_q | mf_fire_s;
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign hi_out    = hi_q;
   assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: a plain-arithmetic HI/LO model feeds
// expected results and HI/LO/latency to a monitor that checks DUT outputs.
module tb_muldiv_iter;
   import muldiv_pkg::*;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = WIDTH + 2;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } hl_t;

   logic        Clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [31:0] rs_in = 32'h0;
   logic [31:0] rt_in = 32'h0;
   logic [31:0] res_out;
   logic        res_valid;
   logic        busy;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   logic [31:0] resq[$];
   hl_t         hlq[$];
   logic [31:0] hi_m = 32'h0;
   logic [31:0] lo_m = 32'h0;
   int          checks = 0;
   int          errors = 0;
   int          bcnt = 0;
   logic        busy_prev = 1'b0;
   hl_t         e_hl;
   logic [31:0] e_res;

   muldiv_iter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .Clk       (Clk),
      .resetn    (resetn),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .rs_in     (rs_in),
      .rt_in     (rt_in),
      .res_out   (res_out),
      .res_valid (res_valid),
      .busy      (busy),
      .hi_out    (hi_out),
      .lo_out    (lo_out)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: what an accepted op does to HI/LO and the result port.
   task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int flush_at);
      longint      sp;
      logic [63:0] up;
      logic [63:0] acc;
      int          sa;
      int          sb;
      hl_t         h;
      sp  = longint'($signed(a)) * longint'($signed(b));
      up  = {32'h0, a} * {32'h0, b};
      acc = {hi_m, lo_m};
      sa  = $signed(a);
      sb  = $signed(b);
      if (flush_at > 0) begin
         h.hi = hi_m; h.lo = lo_m; h.lat = flush_at;
         hlq.push_back(h);
      end else begin
         case (op)
            OP_MFHI:  resq.push_back(hi_m);
            OP_MFLO:  resq.push_back(lo_m);
            OP_MTHI:  hi_m = a;
            OP_MTLO:  lo_m = a;
            OP_MUL:   resq.push_back(sp[31:0]);
            OP_MULT:  {hi_m, lo_m} = sp;
            OP_MULTU: {hi_m, lo_m} = up;
            OP_MADD:  {hi_m, lo_m} = acc + sp;
            OP_MADDU: {hi_m, lo_m} = acc + up;
            OP_MSUB:  {hi_m, lo_m} = acc - sp;
            OP_MSUBU: {hi_m, lo_m} = acc - up;
            OP_DIV: begin
               if (b == 32'h0) begin
                  lo_m = 32'hFFFF_FFFF; hi_m = a;
               end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  lo_m = 32'h8000_0000; hi_m = 32'h0;
               end else begin
                  lo_m = sa / sb; hi_m = sa % sb;
               end
            end
            OP_DIVU: begin
               if (b == 32'h0) begin
                  lo_m = 32'hFFFF_FFFF; hi_m = a;
               end else begin
                  lo_m = a / b; hi_m = a % b;
               end
            end
            default: ;
         endcase
         if (op >= OP_MUL && op <= OP_MSUBU) begin
            h.hi = hi_m; h.lo = lo_m; h.lat = MUL_LAT;
            hlq.push_back(h);
         end else if (op == OP_DIV || op == OP_DIVU) begin
            h.hi = hi_m; h.lo = lo_m; h.lat = DIV_LAT;
            hlq.push_back(h);
         end
      end
   endtask

   // Present a request, wait (bounded) for ready, record the expectation, release.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int waits);
      waits     = 0;
      req_valid = 1'b1;
      req_op    = op;
      rs_in     = a;
      rt_in     = b;
      @(negedge Clk);
      while (!req_ready && waits < 200) begin
         waits++;
         @(negedge Clk);
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: req_ready still 0 after %0d cycles, op %0d", waits, op);
      end else begin
         model_accept(op, a, b, flush_at);
         @(posedge Clk);
      end
      #1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
   endtask

   task automatic settle_after_mul();
      repeat (MUL_LAT + 1) @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return $urandom_range(0, 15);
         default: return $urandom();
      endcase
   endfunction

   // Monitor: pops expectations when the DUT shows a result or finishes a busy op.
   always @(negedge Clk) begin
      #1;
      if (!resetn) begin
         busy_prev = 1'b0;
         bcnt      = 0;
      end else begin
         if (res_valid) begin
            if (resq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL res_unexpected: got res_out %0h expected no result", res_out);
            end else begin
               e_res = resq.pop_front();
               check("res_out", res_out, e_res);
            end
         end
         if (busy) begin
            bcnt++;
         end else if (busy_prev) begin
            if (hlq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL busy_unexpected: got busy op of %0d cycles expected none", bcnt);
            end else begin
               e_hl = hlq.pop_front();
               check("hi_out", hi_out, e_hl.hi);
               check("lo_out", lo_out, e_hl.lo);
               check("busy_cycles", bcnt, e_hl.lat);
            end
            bcnt = 0;
         end
         busy_prev = busy;
      end
   end

   initial begin
      int         w;
      logic [3:0] op;
      #2;
      check("rst_hi", hi_out, 32'h0);
      check("rst_lo", lo_out, 32'h0);
      check("rst_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_out", res_out, 32'h0);
      repeat (2) @(posedge Clk);
      #1 resetn = 1'b1;

      issue(OP_MTHI, 32'h1234_5678, 32'h0, 0, w);
      issue(OP_MFHI, 32'h0, 32'h0, 0, w);
      issue(OP_MTLO, 32'hCAFE_F00D, 32'h0, 0, w);
      @(posedge Clk);
      #3 resetn = 1'b0;
      #1;
      check("async_rst_hi", hi_out, 32'h0);
      check("async_rst_lo", lo_out, 32'h0);
      hi_m = 32'h0;
      lo_m = 32'h0;
      @(posedge Clk);
      #1 resetn = 1'b1;

      issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 0, w);
      issue(OP_MFHI, 32'h0, 32'h0, 0, w);
      check("mult_stall_waits", w, MUL_LAT);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 0, w);
      issue(OP_MTHI, 32'h0, 32'h0, 0, w);
      issue(OP_MTLO, 32'h5, 32'h0, 0, w);
      issue(OP_MADD, 32'h3, 32'h4, 0, w);
      issue(OP_MSUB, 32'hA, 32'h2, 0, w);
      issue(OP_MUL, 32'hFFFF_FFFD, 32'h7, 0, w);
      settle_after_mul();
      issue(OP_MFLO, 32'h0, 32'h0, 0, w);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, w);
      issue(OP_DIVU, 32'd100, 32'd7, 0, w);
      issue(OP_DIVU, 32'd5, 32'd0, 0, w);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, w);
      issue(OP_DIV, 32'hFFFF_FFF0, 32'h0, 0, w);
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, w);

      issue(OP_DIV, 32'd1000, 32'd3, 10, w);
      repeat (9) @(posedge Clk);
      #1 flush = 1'b1;
      @(posedge Clk);
      #1 flush = 1'b0;
      issue(OP_MFLO, 32'h0, 32'h0, 0, w);

      issue(OP_DIVU, 32'd12345, 32'd100, 0, w);
      issue(OP_MFLO, 32'h0, 32'h0, 0, w);
      check("mflo_stall_waits", w, DIV_LAT);

      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = OP_MFHI;
      @(negedge Clk);
      #1 check("flush_mf_dropped", res_valid, 1'b0);
      @(posedge Clk);
      #1;
      req_op = OP_MTLO;
      rs_in  = 32'hDEAD_BEEF;
      @(posedge Clk);
      #1;
      flush     = 1'b0;
      req_valid = 1'b0;
      issue(OP_MFLO, 32'h0, 32'h0, 0, w);

      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(0, 15));
         issue(op, rand_operand(), rand_operand(), 0, w);
         if (op == OP_MUL) settle_after_mul();
      end
      issue(OP_MFHI, 32'h0, 32'h0, 0, w);
      issue(OP_MFLO, 32'h0, 32'h0, 0, w);

      repeat (60) @(posedge Clk);
      #1;
      check("res_queue_drained", resq.size(), 0);
      check("hilo_queue_drained", hlq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
